// File: rtl/rv32_scoreboard.sv
// rtl/rv32_scoreboard.sv - register-hazard scoreboard with one-deep registered issue stage
package rv32_pkg;
    typedef struct packed {
        logic [31:0] inst;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [11:0] funct12;
        logic [31:0] imm;
        logic        decode_error;
    } rv32_fields_t;
endpackage

module rv32_scoreboard
    import rv32_pkg::*;
#(
    parameter int CNT_WIDTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  rv32_fields_t in_fields,
    input  logic         in_uses_rs1,
    input  logic         in_uses_rs2,
    input  logic         in_writes_rd,
    output logic         out_valid,
    input  logic         out_ready,
    output rv32_fields_t out_fields,
    input  logic         wb_valid,
    input  logic [4:0]   wb_rd,
    output logic         busy,
    output logic         wb_error
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // x0 has no counter; pending/full bit 0 stay tied low.
    logic [CNT_WIDTH-1:0] cnt_q [1:31];
    logic [31:0]          pending;
    logic [31:0]          full;
    logic                 hazard;
    logic                 accept;
    logic                 alloc;
    logic                 wb_live;
    logic                 wb_retire;
    logic                 wb_bad;
    logic [31:0]          inc_vec;
    logic [31:0]          dec_vec;

    always_comb begin
        pending = '0;
        full    = '0;
        for (int i = 1; i < 32; i++) begin
            pending[i] = (cnt_q[i] != '0);
            full[i]    = (cnt_q[i] == CNT_MAX);
        end
    end

    // Hazards use registered counts only: a writeback frees its register next cycle.
    always_comb begin
        hazard = 1'b0;
        if (!in_fields.decode_error) begin
            hazard = (in_uses_rs1  && pending[in_fields.rs1]) ||
                     (in_uses_rs2  && pending[in_fields.rs2]) ||
                     (in_writes_rd && full[in_fields.rd]);
        end
    end

    assign in_ready  = (!out_valid || out_ready) && !hazard;
    assign accept    = in_valid && in_ready;
    assign alloc     = accept && in_writes_rd && !in_fields.decode_error && (in_fields.rd != 5'd0);
    assign wb_live   = wb_valid && (wb_rd != 5'd0);
    assign wb_retire = wb_live && pending[wb_rd];
    assign wb_bad    = wb_live && !pending[wb_rd];

    assign inc_vec = alloc     ? (32'd1 << in_fields.rd) : 32'd0;
    assign dec_vec = wb_retire ? (32'd1 << wb_rd)        : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_ONE;
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    cnt_q[i] <= cnt_q[i] - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_fields <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_fields <= in_fields;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_error <= 1'b0;
        end else if (wb_bad) begin
            wb_error <= 1'b1;
        end
    end

    assign busy = |pending;

endmodule
